// File: rtl/bcd_countdown_timer_pkg.sv
// Shared definitions for the two-digit BCD countdown timer and its helpers.
package bcd_countdown_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX_DIGIT    = 4'd9;
    localparam int         DEFAULT_TICK_DIV = 16384;

    // Out-of-range nibbles from the switches saturate to 9 rather than wrapping.
    function automatic logic [7:0] bcd_clamp(input logic [7:0] v);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = (v[7:4] > BCD_MAX_DIGIT) ? BCD_MAX_DIGIT : v[7:4];
        units = (v[3:0] > BCD_MAX_DIGIT) ? BCD_MAX_DIGIT : v[3:0];
        return {tens, units};
    endfunction

endpackage

// File: rtl/Seven_seg.sv
// BCD digit to seven-segment decoder, segments {g,f,e,d,c,b,a}, active high.
// Latency: combinational. Backpressure: none.
// blank=1 darkens every segment; non-decimal codes also stay dark.
module Seven_seg (
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h00;
        if (!blank) begin
            case (digit)
                4'd0:    seg = 7'h3F;
                4'd1:    seg = 7'h06;
                4'd2:    seg = 7'h5B;
                4'd3:    seg = 7'h4F;
                4'd4:    seg = 7'h66;
                4'd5:    seg = 7'h6D;
                4'd6:    seg = 7'h7D;
                4'd7:    seg = 7'h07;
                4'd8:    seg = 7'h7F;
                4'd9:    seg = 7'h6F;
                default: seg = 7'h00;
            endcase
        end
    end

endmodule

// File: rtl/bcd2_dec_step.sv
// Two-digit BCD decrement by one, with a flag for "result is 00".
// Latency: combinational. Backpressure: none.
// 00 saturates at 00 so the result always stays inside 00-99.
module bcd2_dec_step
    import bcd_countdown_timer_pkg::*;
(
    input  logic [7:0] bcd_in,
    output logic [7:0] bcd_dec,
    output logic       next_is_zero
);

    always_comb begin
        bcd_dec = bcd_in;
        if (bcd_in[3:0] != 4'd0) begin
            bcd_dec = {bcd_in[7:4], bcd_in[3:0] - 4'd1};
        end else if (bcd_in[7:4] != 4'd0) begin
            bcd_dec = {bcd_in[7:4] - 4'd1, BCD_MAX_DIGIT};
        end
    end

    assign next_is_zero = (bcd_in == 8'h01);

endmodule

// File: rtl/bcd_countdown_timer.sv
// Two-digit BCD countdown timer with preset load, start/pause, expiry pulse and display.
// Latency: count/flags registered, one step per TICK_DIV cycles; segments are combinational.
// Backpressure: none; control pulses are acted on the cycle they arrive.
module bcd_countdown_timer
    import bcd_countdown_timer_pkg::*;
#(
    parameter int TICK_DIV = DEFAULT_TICK_DIV,
    parameter int TICK_W   = 14
) (
    input  logic       clk_div,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] preset,
    input  logic       start,
    input  logic       pause,
    output logic [7:0] count,
    output logic       running,
    output logic       done,
    output logic       expire,
    output logic [6:0] MSB,
    output logic [6:0] LSB
);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    state_t            state;
    logic [TICK_W-1:0] prescaler;
    logic [7:0]        count_dec;
    logic              next_is_zero;
    logic              tick;
    logic              msb_blank;
    logic              lsb_blank;

    bcd2_dec_step u_dec (
        .bcd_in       (count),
        .bcd_dec      (count_dec),
        .next_is_zero (next_is_zero)
    );

    assign tick = (prescaler == TICK_LAST);

    always_ff @(posedge clk_div or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            count     <= 8'h00;
            prescaler <= '0;
            running   <= 1'b0;
            done      <= 1'b0;
            expire    <= 1'b0;
        end else begin
            expire <= 1'b0;
            if (load && state != ST_RUN) begin
                state     <= ST_IDLE;
                count     <= bcd_clamp(preset);
                prescaler <= '0;
                running   <= 1'b0;
                done      <= 1'b0;
            end else begin
                case (state)
                    ST_RUN: begin
                        // A step due this cycle is applied even if pause arrives with it;
                        // a terminal step lands in DONE regardless of pause.
                        if (tick) begin
                            prescaler <= '0;
                            count     <= count_dec;
                            if (next_is_zero) begin
                                state   <= ST_DONE;
                                running <= 1'b0;
                                done    <= 1'b1;
                                expire  <= 1'b1;
                            end else if (pause) begin
                                state   <= ST_PAUSE;
                                running <= 1'b0;
                            end
                        end else if (pause) begin
                            state   <= ST_PAUSE;
                            running <= 1'b0;
                        end else begin
                            prescaler <= prescaler + TICK_W'(1);
                        end
                    end
                    ST_IDLE, ST_PAUSE: begin
                        if (start && count != 8'h00) begin
                            state   <= ST_RUN;
                            running <= 1'b1;
                            if (state == ST_IDLE) begin
                                prescaler <= '0;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Units stays lit outside IDLE so DONE shows a single "0".
    assign msb_blank = (count[7:4] == 4'd0);
    assign lsb_blank = (count == 8'h00) && (state == ST_IDLE);

    Seven_seg u_seg_msb (
        .digit (count[7:4]),
        .blank (msb_blank),
        .seg   (MSB)
    );

    Seven_seg u_seg_lsb (
        .digit (count[3:0]),
        .blank (lsb_blank),
        .seg   (LSB)
    );

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
- Two-digit BCD countdown timer, range 00–99, for the lab display board.
- Loads a preset from switches, counts down one step every TICK_DIV cycles of clk_div, and flags expiry at 00.
- Drives the two seven-segment digits through the team's Seven_seg decoder, with leading-zero blanking.
- Sits beside the up-counter display path, fed by the same clk_div64 divided clock; this is the down-counting counterpart.

Parameters:
- TICK_DIV, 16384: clk_div cycles per count step; legal range 2..16384.
- TICK_W, 14: width of the prescaler counter; must satisfy 2^TICK_W >= TICK_DIV.

Ports:
- clk_div  in  1  divided system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- load  in  1  one-cycle pulse, synchronous to clk_div; loads preset.
- preset  in  8  BCD preset: [7:4] tens, [3:0] units.
- start  in  1  one-cycle pulse; begins or resumes counting.
- pause  in  1  one-cycle pulse; suspends counting.
- count  out  8  current BCD value: [7:4] tens, [3:0] units.
- running  out  1  high while in RUN.
- done  out  1  high while in DONE.
- expire  out  1  one-cycle pulse when count reaches 00 from RUN.
- MSB  out  7  segment code for the tens digit.
- LSB  out  7  segment code for the units digit.

Interface (decided): reset is reset, asynchronous, active-low; clock is clk_div.

Behaviour:
- States (2-bit): IDLE=0, RUN=1, PAUSE=2, DONE=3.
- Reset (async, while reset=0):
  - state=IDLE, count=8'h00, prescaler=0.
  - running=0, done=0, expire=0.
  - Applies immediately, including mid-count; no partial step survives.
- Load:
  - Accepted in IDLE, PAUSE and DONE; ignored in RUN.
  - Any preset nibble >9 is clamped to 9 (e.g. 8'hA3 loads 8'h93).
  - Sets count=clamped preset, prescaler=0, state=IDLE.
- Start:
  - In IDLE or PAUSE with count != 00: go to RUN.
    - From IDLE the prescaler starts at 0.
    - From PAUSE the prescaler resumes from its held value.
  - Ignored when count==00, and ignored in RUN and DONE.
- RUN:
  - Prescaler increments every cycle.
  - When prescaler==TICK_DIV-1: prescaler<=0 and count decrements in BCD.
    - units!=0: units-1.
    - units==0: units=9, tens-1.
  - When the decrement takes count from 01 to 00 (terminal step), on the same edge: state=DONE and expire=1 for exactly one cycle.
  - Step interval is exactly TICK_DIV cycles; the first step comes TICK_DIV cycles after the start edge.
- Pause:
  - In RUN: go to PAUSE with the prescaler held.
  - Ignored in IDLE, PAUSE and DONE.
- Same-cycle priority: load > pause > start.
  - If pause coincides with a step, the step is still applied.
  - If that step is terminal, DONE wins over PAUSE and expire still fires.
- DONE:
  - count held at 00, done=1, start ignored.
  - Only load or reset leaves DONE.
- Output timing:
  - running, done and count are registered.
  - expire is registered and is never high outside the first DONE cycle.
  - MSB/LSB are combinational from the registered count and state (zero-cycle decode).
- Blanking (blank input to Seven_seg high = digit dark):
  - MSB is blanked when tens==0.
  - LSB is blanked only when count==00 and state==IDLE.
  - In RUN, PAUSE and DONE the units digit always shows, so DONE displays a single "0".
- Widths:
  - BCD arithmetic is per nibble; no binary borrow crosses a nibble boundary.
  - count never leaves the BCD range 00–99.

Decomposition:
- Shared package:
  - State encoding constants (IDLE/RUN/PAUSE/DONE).
  - BCD_MAX_DIGIT=4'd9.
  - Default TICK_DIV.
- Sub-module bcd2_dec_step (combinational):
  - Input: 8-bit BCD.
  - Outputs: decremented value and a next_is_zero flag.
  - Reused by later 2-digit down-counting blocks.
- Two Seven_seg instances for display; no other hierarchy.

Test Plan (TICK_DIV overridden to 4):
- Reset mid-RUN at count 8'h37 -> count=00, state IDLE, running=0, done=0, expire=0 on the same cycle, before the next clock edge.
- Load 8'h12, start -> sequence 12, 11, 10, 09 with one step every 4 clk_div cycles; at 10 -> 09, tens goes 1 -> 0 and units 0 -> 9.
- Load 8'h02, start -> after 8 cycles count=00, expire high exactly 1 cycle, done=1, LSB shows "0", MSB blanked; a later start is ignored.
- Load 8'h05, start, pause after 2 cycles, hold 10 cycles, start -> next step comes 2 cycles after resume; count stays 05 throughout pause.
- Load 8'hFB -> count=99; load during RUN ignored; load and start in the same cycle in IDLE -> new value loaded, state stays IDLE.
- Count 01 in RUN, pause asserted on the terminal-step cycle -> state DONE, expire pulses, running=0.
